// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: two one-entry
// holding registers (A, B) committed oldest-first, with stale-read hazard flags.
`timescale 1ns/1ps
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    logic              full_a, full_b;
    logic              age_a, age_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              grant_a, grant_b;
    logic              load_a, load_b;

    // A wins unless B is full and strictly older; equal age ties go to A.
    always_comb begin
        grant_a = full_a & (!full_b | !age_b);
        grant_b = full_b & !grant_a;
    end

    assign a_ready = !full_a | grant_a;
    assign b_ready = !full_b | grant_b;

    // Beats to x0 complete the handshake but are dropped here.
    assign load_a = a_valid & a_ready & (a_addr != '0);
    assign load_b = b_valid & b_ready & (b_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_a <= 1'b0;
            full_b <= 1'b0;
            age_a  <= 1'b0;
            age_b  <= 1'b0;
            addr_a <= '0;
            addr_b <= '0;
            data_a <= '0;
            data_b <= '0;
        end else begin
            if (load_a) begin
                full_a <= 1'b1;
                addr_a <= a_addr;
                data_a <= a_data;
            end else if (grant_a) begin
                full_a <= 1'b0;
            end

            if (load_b) begin
                full_b <= 1'b1;
                addr_b <= b_addr;
                data_b <= b_data;
            end else if (grant_b) begin
                full_b <= 1'b0;
            end

            // A retained entry becomes older when the other side loads behind it.
            if (load_a || grant_a)
                age_a <= 1'b0;
            else if (load_b && full_a)
                age_a <= 1'b1;

            if (load_b || grant_b)
                age_b <= 1'b0;
            else if (load_a && full_b)
                age_b <= 1'b1;
        end
    end

    always_comb begin
        rf_we    = grant_a | grant_b;
        rf_waddr = '0;
        rf_wdata = '0;
        if (grant_a) begin
            rf_waddr = addr_a;
            rf_wdata = data_a;
        end else if (grant_b) begin
            rf_waddr = addr_b;
            rf_wdata = data_b;
        end
    end

    // The committing entry is bypassed by the register file, so it never flags.
    always_comb begin
        hazard1 = (rd_addr1 != '0) &
                  ((full_a & !grant_a & (addr_a == rd_addr1)) |
                   (full_b & !grant_b & (addr_b == rd_addr1)));
        hazard2 = (rd_addr2 != '0) &
                  ((full_a & !grant_a & (addr_a == rd_addr2)) |
                   (full_b & !grant_b & (addr_b == rd_addr2)));
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a capture-order scoreboard checks every commit,
// and the main sequence checks ready, hazard and latency behaviour.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, rd_addr1, rd_addr2, rf_waddr;
    logic [31:0] a_data, b_data, rf_wdata;
    logic        hazard1, hazard2, rf_we;

    int n_cmp = 0;
    int n_err = 0;

    logic [36:0] sb_q[$];
    logic [31:0] rf_model[32];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: commits must come out in capture order (A before B on a tie).
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (rf_we) begin
                if (sb_q.size() == 0) begin
                    chk("commit_unexpected", {27'd0, rf_waddr}, 32'd0);
                end else begin
                    logic [36:0] e;
                    e = sb_q.pop_front();
                    chk("commit_addr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
                    chk("commit_data", rf_wdata, e[31:0]);
                end
                rf_model[rf_waddr] = rf_wdata;
            end else begin
                chk("idle_waddr", {27'd0, rf_waddr}, 32'd0);
                chk("idle_wdata", rf_wdata, 32'd0);
            end
            if (a_valid && a_ready && a_addr != 5'd0) sb_q.push_back({a_addr, a_data});
            if (b_valid && b_ready && b_addr != 5'd0) sb_q.push_back({b_addr, b_data});
        end
    end

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        @(posedge clk); #1;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
        rd_addr1 = 0; rd_addr2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
        chk("rst_haz", {30'd0, hazard1, hazard2}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset mid-traffic: parked x5/x6 must be discarded.
        drive(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_we", {31'd0, rf_we}, 32'd0);
        chk("midrst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("midrst_b_ready", {31'd0, b_ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_x5", rf_model[5], 32'd0);
        chk("midrst_x6", rf_model[6], 32'd0);

        // A streams x1..x4 back-to-back.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 5'(i + 1), 32'hA1 + 32'(i), 0, 5'd0, 32'd0);
            else       drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            chk("stream_a_ready", {31'd0, a_ready}, 32'd1);
            if (i == 0) chk("stream_we0", {31'd0, rf_we}, 32'd0);
            else begin
                chk("stream_we", {31'd0, rf_we}, 32'd1);
                chk("stream_addr", {27'd0, rf_waddr}, 32'(i));
            end
        end
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("stream_done", {31'd0, rf_we}, 32'd0);

        // Simultaneous A/B: A first, B held off for one cycle.
        drive(1, 5'd7, 32'h70, 1, 5'd8, 32'h80);
        chk("sim_a_ready", {31'd0, a_ready}, 32'd1);
        chk("sim_b_ready", {31'd0, b_ready}, 32'd1);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("sim_c1_addr", {27'd0, rf_waddr}, 32'd7);
        chk("sim_c1_b_ready", {31'd0, b_ready}, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("sim_c2_addr", {27'd0, rf_waddr}, 32'd8);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("sim_c3_we", {31'd0, rf_we}, 32'd0);

        // Same-address ordering: B then A to x9, last writer wins.
        drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h1);
        drive(1, 5'd9, 32'h2, 0, 5'd0, 32'd0);
        chk("ord_c1_data", rf_wdata, 32'h1);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("ord_c2_data", rf_wdata, 32'h2);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("ord_x9", rf_model[9], 32'h2);

        // Writes to x0 are accepted and dropped.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0);
            chk("x0_a_ready", {31'd0, a_ready}, 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            chk("x0_we", {31'd0, rf_we}, 32'd0);
            chk("x0_haz", {30'd0, hazard1, hazard2}, 32'd0);
        end

        // Hazard: A(x3) loads behind B(x4) while A(x10) commits, so B becomes older.
        drive(1, 5'd10, 32'h100, 1, 5'd4, 32'h400);
        rd_addr2 = 5'd4;
        drive(1, 5'd3, 32'h300, 0, 5'd0, 32'd0);
        chk("haz_s2_addr", {27'd0, rf_waddr}, 32'd10);
        chk("haz_s2_b_ready", {31'd0, b_ready}, 32'd0);
        chk("haz_s2_hazard2", {31'd0, hazard2}, 32'd1);
        @(posedge clk); #1;
        a_valid = 0; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
        @(negedge clk);
        chk("haz_s3_addr", {27'd0, rf_waddr}, 32'd4);
        chk("haz_s3_hazard1", {31'd0, hazard1}, 32'd1);
        chk("haz_s3_hazard2", {31'd0, hazard2}, 32'd0);
        chk("haz_s3_a_ready", {31'd0, a_ready}, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("haz_s4_addr", {27'd0, rf_waddr}, 32'd3);
        chk("haz_s4_hazard1", {31'd0, hazard1}, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("haz_s5_we", {31'd0, rf_we}, 32'd0);
        chk("final_x3", rf_model[3], 32'h300);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 32 x 32 register file's single write port. Two writers, A (ALU/execute) and B (load/memory), each hand a (register, data) beat over valid/ready. Each beat is parked in a one-entry holding register and committed to the register file oldest-first, one write per cycle. The block also flags reads that would return stale data because a parked write has not yet committed.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers, x0 hardwired zero)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a write beat
- a_ready  out  1  requester A beat accepted this cycle when a_valid & a_ready
- a_addr  in  ADDR_W  destination register of A
- a_data  in  DATA_W  write data of A
- b_valid, b_ready, b_addr, b_data  same as A, for requester B
- rd_addr1, rd_addr2  in  ADDR_W  register-file read addresses issued this cycle
- hazard1, hazard2  out  1  read address matches a parked write that is not committing this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data

## Operation
- State per requester X∈{A,B}:
  - full_X: entry occupied
  - addr_X, data_X: parked beat
  - age_X: 1 if entry was loaded on an earlier cycle than the other full entry
- Capture:
  - On a handshake with a_addr/b_addr != 0, the entry loads at the clock edge and full is set.
  - A handshake with addr == 0 is accepted and discarded: the entry is not loaded and no write ever occurs.
- Ready: X_ready = !full_X | grant_X. Ready is combinational from state only and must not depend on X_valid.
- Grant, evaluated each cycle from registered state:
  - Only A full: grant A. Only B full: grant B.
  - Both full: grant the entry with age set.
  - Both full and loaded on the same edge (no age set): grant A.
- Age:
  - When an entry loads while the other entry is full and not granted that cycle, the other entry's age is set.
  - A granted entry clears its full bit and its age bit.
  - If a new beat loads in the same cycle its entry is granted, full stays 1 and age is recomputed by the rule above.
- Commit: rf_we = grant_A | grant_B. rf_waddr/rf_wdata are muxed from the granted entry, and are all-zero when rf_we = 0.
- Hazard:
  - hazardN = (rd_addrN != 0) & any full, non-granted entry has addr == rd_addrN.
  - A match against the entry committing this cycle is not a hazard, because the register file bypasses the write data.
- Same-address writes from A and B commit in capture order. This guarantees last-writer-wins for in-order requesters.

## Timing
- Reset (async, rst_n = 0):
  - full, age and all entries cleared; parked writes are discarded.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, hazard1/2 = 0, a_ready = b_ready = 1.
- Latency: a handshake at edge n yields rf_we at cycle n+1 if uncontended, or n+2 if the other entry is older.
- Throughput:
  - One commit per cycle total.
  - A single uncontended requester sustains one beat per cycle, since ready stays high via grant.
- Worst-case wait: an entry waits at most one cycle behind the other entry, so there is no starvation.
- Backpressure: X_ready = 0 only when full_X and the other entry is granted.
- Simultaneous valid on A and B with both entries empty: both are accepted on the same edge. A commits first, then B, with B_ready low during A's commit cycle.
- Deassertion of rst_n is synchronized externally. The first handshake is allowed on the first edge after release.

## Test plan
- Reset mid-traffic: park A (x5, 0x11) and B (x6, 0x22), assert rst_n = 0 -> rf_we = 0 immediately, both readies = 1, and no write to x5/x6 after release.
- A alone streams x1..x4 with data 0xA1..0xA4, back-to-back -> a_ready constant 1, rf_we on 4 consecutive cycles one cycle after each beat, addresses in order.
- A and B both valid on the same cycle (A x7 = 0x70, B x8 = 0x80) -> cycle 1 commits x7 with b_ready = 0, cycle 2 commits x8.
- Ordering: B (x9, 0x1) captured at cycle 0, A (x9, 0x2) captured at cycle 1 while B still waits -> B commits first, A second, and x9 reads 0x2 at the end.
- Writes to x0: a_valid with a_addr = 0 for 3 cycles -> a_ready = 1, rf_we never asserted, hazards never asserted.
- Hazard: A (x3) parked behind an older B (x4), rd_addr1 = 3, rd_addr2 = 4 -> hazard1 = 1 and hazard2 = 0 (B committing). Next cycle, with A committing, hazard1 = 0.
